// File: rtl/mips_pkg.sv
// Shared constants for the MIPS_UART multi-cycle control unit:
// opcode/funct codes, ALU_Sel codes, mux encodings and FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRADR  = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'd0,
    ALU_CLS_RTYPE = 2'd1,
    ALU_CLS_IMM   = 2'd2
  } alu_cls_e;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control <-> datapath bundle: IR fields, zero, mem_ready in;
// datapath enables, selects, ALU_Sel and illegal_op out.
interface mips_mc_control_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtOp;
  logic [2:0] ALU_Sel;
  logic       illegal_op;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output PCWrite, PCSrc, IorD, MemRead,
    output MemWrite, IRWrite, RegDst,
    output MemtoReg, RegWrite, ALUSrcA,
    output ALUSrcB, ExtOp, ALU_Sel,
    output illegal_op
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  PCWrite, PCSrc, IorD, MemRead,
    input  MemWrite, IRWrite, RegDst,
    input  MemtoReg, RegWrite, ALUSrcA,
    input  ALUSrcB, ExtOp, ALU_Sel,
    input  illegal_op
  );

endinterface

// File: rtl/mips_alu_dec.sv
// ALU operation decoder: (class, opcode, funct) -> alu_sel, plus
// funct_ok flagging a supported R-type funct.
module mips_alu_dec
  import mips_pkg::*;
(
  input  alu_cls_e   cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_sel,
  output logic       funct_ok
);

  logic [2:0] r_sel;

  always_comb begin
    r_sel    = ALU_ADD;
    funct_ok = 1'b1;
    unique case (1'b1)
      funct == FN_SLL:  r_sel = ALU_SLL;
      funct == FN_ADD:  r_sel = ALU_ADD;
      funct == FN_ADDU: r_sel = ALU_ADD;
      funct == FN_AND:  r_sel = ALU_AND;
      funct == FN_OR:   r_sel = ALU_OR;
      default:          funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_sel = ALU_ADD;
    unique case (cls)
      ALU_CLS_RTYPE: alu_sel = r_sel;
      ALU_CLS_IMM: begin
        unique case (1'b1)
          opcode == OP_ANDI: alu_sel = ALU_AND;
          opcode == OP_ORI:  alu_sel = ALU_OR;
          default:           alu_sel = ALU_ADD;
        endcase
      end
      default: alu_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM. Ports: clk, rst_n, bus (master
// side of mips_mc_control_if), state (debug view of the FSM).
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_mc_control_if.master  bus,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  alu_cls_e cls;
  logic [2:0] alu_sel;
  logic funct_ok;

  logic       pc_write, mem_read, mem_write;
  logic       ir_write, reg_write, illegal;
  logic [1:0] pc_src, src_b;
  logic       iord, reg_dst, mem_to_reg;
  logic       src_a, ext_op;

  mips_alu_dec u_alu_dec (
    .cls      (cls),
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .alu_sel  (alu_sel),
    .funct_ok (funct_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    cls        = ALU_CLS_ADD;
    pc_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    pc_src     = PCSRC_ALU;
    src_b      = SRCB_REG;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    src_a      = 1'b0;
    ext_op     = 1'b1;
    unique case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        src_b    = SRCB_FOUR;
        ir_write = bus.mem_ready;
        state_d  = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_ALUOUT;
        unique case (1'b1)
          bus.opcode == OP_RTYPE:
            state_d = funct_ok ? S_EXEC : S_TRAP;
          bus.opcode == OP_LW,
          bus.opcode == OP_SW:
            state_d = S_MEMADR;
          bus.opcode == OP_ADDI,
          bus.opcode == OP_ANDI,
          bus.opcode == OP_ORI:
            state_d = S_IEXEC;
          bus.opcode == OP_BEQ,
          bus.opcode == OP_BNE:
            state_d = S_BRADR;
          bus.opcode == OP_J:
            state_d = S_JUMP;
          default:
            state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        src_a   = 1'b1;
        cls     = ALU_CLS_RTYPE;
        state_d = S_RWB;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_MEMADR: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      // Address-phase ALU controls are held so ALU_Out stays put.
      S_MEMRD: begin
        src_a    = 1'b1;
        src_b    = SRCB_IMM;
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWR: begin
        src_a     = 1'b1;
        src_b     = SRCB_IMM;
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_IEXEC: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        cls     = ALU_CLS_IMM;
        ext_op  = (bus.opcode == OP_ADDI);
        state_d = S_IWB;
      end
      S_IWB: reg_write = 1'b1;
      // PC already holds PC+4 after DECODE.
      S_BRADR: begin
        src_b   = SRCB_BOFF;
        state_d = S_BRANCH;
      end
      S_BRANCH: begin
        pc_src   = PCSRC_ALUOUT;
        pc_write = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are gated by rst_n so nothing writes while in reset.
  assign bus.PCWrite    = rst_n & pc_write;
  assign bus.MemRead    = rst_n & mem_read;
  assign bus.MemWrite   = rst_n & mem_write;
  assign bus.IRWrite    = rst_n & ir_write;
  assign bus.RegWrite   = rst_n & reg_write;
  assign bus.illegal_op = rst_n & illegal;
  assign bus.PCSrc      = pc_src;
  assign bus.IorD       = iord;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ExtOp      = ext_op;
  assign bus.ALU_Sel    = alu_sel;
  assign state          = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed self-checking bench for mips_mc_control.
// Each task starts and ends just after a rising edge in FETCH.
module tb_mips_mc_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] state;
  int checks = 0;
  int errors = 0;

  mips_mc_control_if bus ();

  mips_mc_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] wen();
    return {bus.PCWrite, bus.IRWrite, bus.MemWrite,
            bus.RegWrite, bus.MemRead};
  endfunction

  task automatic test_reset();
    bus.opcode = 6'h00;
    bus.funct = 6'h20;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL rst_state got %0d want 0", state);
    end
    checks++;
    if (wen() !== 5'b0 || bus.illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL rst_en got %b/%b want 0", wen(), bus.illegal_op);
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (state !== 4'd0 || bus.MemRead !== 1'b1 || bus.IRWrite !== 1'b0) begin
      errors++;
      $display("FAIL fetch_stall got st=%0d rd=%b ir=%b want 0/1/0",
               state, bus.MemRead, bus.IRWrite);
    end
  endtask

  task automatic test_add();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    bus.opcode = 6'h00;
    bus.funct = 6'h20;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if ({bus.IRWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALU_Sel} !== 7'b1_0_01_010) begin
      errors++;
      $display("FAIL add_fetch got %b want 1001010",
               {bus.IRWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALU_Sel});
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== exp_st[i] ||
          bus.RegWrite !== (exp_st[i] == 4'd7) ||
          bus.RegDst !== (exp_st[i] == 4'd7)) begin
        errors++;
        $display("FAIL add_seq[%0d] got st=%0d rw=%b rd=%b want st=%0d",
                 i, state, bus.RegWrite, bus.RegDst, exp_st[i]);
      end
      if (exp_st[i] == 4'd1) begin
        checks++;
        if (bus.PCWrite !== 1'b1 || bus.PCSrc !== 2'b01) begin
          errors++;
          $display("FAIL add_decode got pcw=%b src=%b want 1/01",
                   bus.PCWrite, bus.PCSrc);
        end
      end
      if (exp_st[i] == 4'd6) begin
        checks++;
        if ({bus.ALU_Sel, bus.ALUSrcA, bus.ALUSrcB} !== 6'b010_1_00) begin
          errors++;
          $display("FAIL add_exec got %b want 010100",
                   {bus.ALU_Sel, bus.ALUSrcA, bus.ALUSrcB});
        end
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_lw_stall();
    int n = 0;
    bus.opcode = 6'h23;
    bus.mem_ready = 1'b1;
    step();
    step();
    checks++;
    if (state !== 4'd2 ||
        {bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp, bus.ALU_Sel} !== 7'b1_10_1_010) begin
      errors++;
      $display("FAIL lw_memadr got st=%0d ctl=%b want 2/1101010",
               state, {bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp, bus.ALU_Sel});
    end
    bus.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 10 && state == 4'd3; i++) begin
      bus.mem_ready = (n == 3);
      #1;
      n++;
      checks++;
      if ({bus.IorD, bus.MemRead, bus.ALUSrcA, bus.ALUSrcB,
           bus.ExtOp, bus.ALU_Sel, bus.RegWrite} !== 10'b1_1_1_10_1_010_0) begin
        errors++;
        $display("FAIL lw_memrd[%0d] got %b want 1111010100", i,
                 {bus.IorD, bus.MemRead, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ExtOp, bus.ALU_Sel, bus.RegWrite});
      end
      step();
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL lw_stall_len got %0d want 4", n);
    end
    checks++;
    if (state !== 4'd4 ||
        {bus.MemtoReg, bus.RegWrite, bus.RegDst} !== 3'b110) begin
      errors++;
      $display("FAIL lw_memwb got st=%0d %b want 4/110",
               state, {bus.MemtoReg, bus.RegWrite, bus.RegDst});
    end
    step();
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL lw_end got %0d want 0", state);
    end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z,
                             input logic exp_pcw);
    bus.opcode = op;
    bus.zero = ~z;
    bus.mem_ready = 1'b1;
    step();
    step();
    checks++;
    if (state !== 4'd10 ||
        {bus.ALUSrcA, bus.ALUSrcB, bus.ALU_Sel, bus.PCWrite} !== 7'b0_11_010_0) begin
      errors++;
      $display("FAIL br_adr got st=%0d %b want 10/0110100",
               state, {bus.ALUSrcA, bus.ALUSrcB, bus.ALU_Sel, bus.PCWrite});
    end
    step();
    bus.zero = z;
    #1;
    checks++;
    if (state !== 4'd11 || bus.PCWrite !== exp_pcw || bus.PCSrc !== 2'b01) begin
      errors++;
      $display("FAIL br op=%h z=%b got st=%0d pcw=%b src=%b want 11/%b/01",
               op, z, state, bus.PCWrite, bus.PCSrc, exp_pcw);
    end
    step();
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL br_end got %0d want 0", state);
    end
  endtask

  task automatic test_sll_ori();
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.mem_ready = 1'b1;
    step();
    step();
    checks++;
    if (state !== 4'd6 || bus.ALU_Sel !== 3'b111 || bus.ALUSrcB !== 2'b00) begin
      errors++;
      $display("FAIL sll got st=%0d sel=%b srcb=%b want 6/111/00",
               state, bus.ALU_Sel, bus.ALUSrcB);
    end
    step();
    step();
    bus.opcode = 6'h0D;
    step();
    step();
    checks++;
    if (state !== 4'd8 ||
        {bus.ALU_Sel, bus.ExtOp, bus.ALUSrcA, bus.ALUSrcB} !== 7'b001_0_1_10) begin
      errors++;
      $display("FAIL ori got st=%0d %b want 8/0010110",
               state, {bus.ALU_Sel, bus.ExtOp, bus.ALUSrcA, bus.ALUSrcB});
    end
    step();
    checks++;
    if (state !== 4'd9 ||
        {bus.RegWrite, bus.RegDst, bus.MemtoReg} !== 3'b100) begin
      errors++;
      $display("FAIL ori_wb got st=%0d %b want 9/100",
               state, {bus.RegWrite, bus.RegDst, bus.MemtoReg});
    end
    step();
    bus.opcode = 6'h0C;
    step();
    step();
    checks++;
    if (bus.ALU_Sel !== 3'b000 || bus.ExtOp !== 1'b0) begin
      errors++;
      $display("FAIL andi got sel=%b ext=%b want 000/0", bus.ALU_Sel, bus.ExtOp);
    end
    bus.opcode = 6'h08;
    #1;
    checks++;
    if (bus.ALU_Sel !== 3'b010 || bus.ExtOp !== 1'b1) begin
      errors++;
      $display("FAIL addi got sel=%b ext=%b want 010/1", bus.ALU_Sel, bus.ExtOp);
    end
    step();
    step();
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct = fn;
    bus.mem_ready = 1'b1;
    step();
    checks++;
    if (bus.illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL ill_early got %b want 0", bus.illegal_op);
    end
    step();
    checks++;
    if (state !== 4'd13 || bus.illegal_op !== 1'b1 || wen() !== 5'b0) begin
      errors++;
      $display("FAIL ill op=%h fn=%h got st=%0d ill=%b en=%b want 13/1/0",
               op, fn, state, bus.illegal_op, wen());
    end
    step();
    checks++;
    if (state !== 4'd0 || bus.illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL ill_end got st=%0d ill=%b want 0/0", state, bus.illegal_op);
    end
  endtask

  task automatic test_jump_sw();
    bus.opcode = 6'h02;
    bus.mem_ready = 1'b1;
    step();
    step();
    checks++;
    if (state !== 4'd12 || bus.PCWrite !== 1'b1 || bus.PCSrc !== 2'b10) begin
      errors++;
      $display("FAIL jump got st=%0d pcw=%b src=%b want 12/1/10",
               state, bus.PCWrite, bus.PCSrc);
    end
    step();
    bus.opcode = 6'h2B;
    step();
    step();
    step();
    checks++;
    if (state !== 4'd5 || bus.MemWrite !== 1'b1 || bus.IorD !== 1'b1) begin
      errors++;
      $display("FAIL sw got st=%0d mw=%b iord=%b want 5/1/1",
               state, bus.MemWrite, bus.IorD);
    end
    step();
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL sw_end got %0d want 0", state);
    end
  endtask

  task automatic test_reset_midwrite();
    bus.opcode = 6'h2B;
    bus.mem_ready = 1'b1;
    step();
    step();
    bus.mem_ready = 1'b0;
    step();
    #1;
    checks++;
    if (state !== 4'd5 || bus.MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL rmw_pre got st=%0d mw=%b want 5/1", state, bus.MemWrite);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.MemWrite !== 1'b0 || wen() !== 5'b0 || state !== 4'd0) begin
      errors++;
      $display("FAIL rmw_abort got mw=%b en=%b st=%0d want 0/0/0",
               bus.MemWrite, wen(), state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (state !== 4'd0 || bus.MemRead !== 1'b1 || bus.MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL rmw_post got st=%0d rd=%b mw=%b want 0/1/0",
               state, bus.MemRead, bus.MemWrite);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_branch(6'h04, 1'b1, 1'b1);
    test_branch(6'h04, 1'b0, 1'b0);
    test_branch(6'h05, 1'b1, 1'b0);
    test_branch(6'h05, 1'b0, 1'b1);
    test_sll_ori();
    test_illegal(6'h3F, 6'h20);
    test_illegal(6'h00, 6'h2A);
    test_jump_sw();
    test_reset_midwrite();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
